// File: rtl/z3_slave_pkg.sv
// ============================================================================
// Module      : z3_slave_pkg
// Description : Shared state encodings and region indices for the Zorro III
//               slave-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package z3_slave_pkg;

    localparam logic [1:0] Z3_IDLE  = 2'd0;
    localparam logic [1:0] Z3_START = 2'd1;
    localparam logic [1:0] Z3_DATA  = 2'd2;
    localparam logic [1:0] Z3_END   = 2'd3;

    // Bit positions of the board's default decoded regions in REGION_SEL/ACK
    localparam int REGION_ROM        = 0;
    localparam int REGION_SCSI       = 1;
    localparam int REGION_INTREG     = 2;
    localparam int REGION_IDREG      = 3;
    localparam int REGION_AUTOCONFIG = 4;
    localparam int NUM_DEFAULT_REGIONS = 5;

endpackage

`default_nettype wire

// File: rtl/sig_sync.sv
// ============================================================================
// Module      : sig_sync
// Description : Generic N-stage single-bit synchroniser with synchronous
//               active-high clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sig_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/z3_slave_ctrl.sv
// ============================================================================
// Module      : z3_slave_ctrl
// Description : Zorro III slave-cycle sequencer (IDLE/START/DATA/END) for
//               N decoded regions; issues registered DTACK or, when the
//               Z3_SLAVE_TIMEOUT_EN macro is defined, BERR on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module z3_slave_ctrl
    import z3_slave_pkg::*;
#(
    parameter int NUM_REGIONS    = 5,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FCS_n,
    input  logic                   MATCH,
    input  logic                   VALIDSPACE,
    input  logic [NUM_REGIONS-1:0] REGION_SEL,
    input  logic [3:0]             DS_n,
    input  logic                   DOE,
    input  logic [NUM_REGIONS-1:0] REGION_ACK,
    output logic                   DTACK,
    output logic                   BERR,
    output logic                   CYCLE_ACTIVE,
    output logic [NUM_REGIONS-1:0] CYCLE_REGION,
    output logic [1:0]             STATE
);

    generate
        if (NUM_REGIONS < 1 || NUM_REGIONS > 16 || SYNC_STAGES < 2 ||
            TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
            $error("z3_slave_ctrl: parameter out of range");
        end
    endgenerate

    logic [1:0]             r_state;
    logic                   r_dtack;
    logic [NUM_REGIONS-1:0] r_region;
    logic                   w_ds_act;
    logic                   w_ds_sync;
    logic                   w_doe_sync;
    logic                   w_any_sel;
    logic                   w_ack;
    logic                   w_found;
    logic [NUM_REGIONS-1:0] w_low_sel;

    assign w_ds_act = (DS_n != 4'hF);

    sig_sync #(.STAGES(SYNC_STAGES)) u_ds_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (w_ds_act),
        .q   (w_ds_sync)
    );

    sig_sync #(.STAGES(SYNC_STAGES)) u_doe_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (DOE),
        .q   (w_doe_sync)
    );

    // Multi-hot decoder output resolves to the lowest index
    always_comb begin
        w_low_sel = '0;
        w_found   = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (REGION_SEL[i] && !w_found) begin
                w_low_sel[i] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign w_any_sel = |REGION_SEL;
    assign w_ack     = |(REGION_ACK & r_region);

`ifdef Z3_SLAVE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;
    logic          r_berr;
    logic          w_timeout;

    assign w_timeout = (r_count == CW'(TIMEOUT_CYCLES - 1));

    // Held at zero outside DATA so entry into DATA always starts from 0
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else if (r_state != Z3_DATA) begin
            r_count <= '0;
        end else if (r_count != CW'(TIMEOUT_CYCLES)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign BERR = r_berr;
`else
    assign BERR = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= Z3_IDLE;
            r_dtack  <= 1'b0;
            r_region <= '0;
`ifdef Z3_SLAVE_TIMEOUT_EN
            r_berr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                Z3_IDLE: begin
                    if (!FCS_n && MATCH && VALIDSPACE && w_any_sel) begin
                        r_state  <= Z3_START;
                        r_region <= w_low_sel;
                    end
                end
                Z3_START: begin
                    if (FCS_n) begin
                        r_state  <= Z3_IDLE;
                        r_region <= '0;
                    end else if (w_doe_sync && w_ds_sync) begin
                        r_state <= Z3_DATA;
                    end
                end
                Z3_DATA: begin
                    if (FCS_n) begin
                        r_state  <= Z3_IDLE;
                        r_region <= '0;
                    end else if (w_ack) begin
                        r_state <= Z3_END;
                        r_dtack <= 1'b1;
                    end
`ifdef Z3_SLAVE_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_state <= Z3_END;
                        r_berr  <= 1'b1;
                    end
`endif
                end
                Z3_END: begin
                    if (FCS_n) begin
                        r_state  <= Z3_IDLE;
                        r_dtack  <= 1'b0;
                        r_region <= '0;
`ifdef Z3_SLAVE_TIMEOUT_EN
                        r_berr   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state  <= Z3_IDLE;
                    r_dtack  <= 1'b0;
                    r_region <= '0;
                end
            endcase
        end
    end

    assign DTACK        = r_dtack;
    assign CYCLE_ACTIVE = (r_state != Z3_IDLE);
    assign CYCLE_REGION = r_region;
    assign STATE        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_z3_slave_ctrl.sv
// ============================================================================
// Module      : tb_z3_slave_ctrl
// Description : Self-checking bench for z3_slave_ctrl; timeout scenarios
//               follow the Z3_SLAVE_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z3_slave_ctrl;

    localparam int NR = 5;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_END   = 2'd3;

    typedef struct packed {
        logic [1:0]    st;
        logic          dt;
        logic          be;
        logic [NR-1:0] rg;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fcs_n = 1'b1;
    logic          match = 1'b0;
    logic          validspace = 1'b0;
    logic [NR-1:0] region_sel = '0;
    logic [3:0]    ds_n = 4'hF;
    logic          doe = 1'b0;
    logic [NR-1:0] region_ack = '0;
    logic          dtack;
    logic          berr;
    logic          cycle_active;
    logic [NR-1:0] cycle_region;
    logic [1:0]    state;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    z3_slave_ctrl #(
        .NUM_REGIONS    (NR),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .FCS_n        (fcs_n),
        .MATCH        (match),
        .VALIDSPACE   (validspace),
        .REGION_SEL   (region_sel),
        .DS_n         (ds_n),
        .DOE          (doe),
        .REGION_ACK   (region_ack),
        .DTACK        (dtack),
        .BERR         (berr),
        .CYCLE_ACTIVE (cycle_active),
        .CYCLE_REGION (cycle_region),
        .STATE        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Queue the expected post-edge outputs, clock once, then compare
    task automatic step(input string tag, input logic [1:0] st, input logic dt,
                        input logic be, input logic [NR-1:0] rg);
        exp_t e;
        e.st = st; e.dt = dt; e.be = be; e.rg = rg;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_state"},  32'(state),        32'(e.st));
        chk({tag, "_dtack"},  32'(dtack),        32'(e.dt));
        chk({tag, "_berr"},   32'(berr),         32'(e.be));
        chk({tag, "_active"}, 32'(cycle_active), 32'(e.st != S_IDLE));
        chk({tag, "_region"}, 32'(cycle_region), 32'(e.rg));
    endtask

    task automatic drive(input logic f, input logic m, input logic [NR-1:0] sel,
                         input logic act, input logic [NR-1:0] ack);
        fcs_n      = f;
        match      = m;
        validspace = m;
        region_sel = sel;
        ds_n       = act ? 4'h0 : 4'hF;
        doe        = act;
        region_ack = ack;
    endtask

    task automatic idle_gap(input string tag);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(tag, S_IDLE, 1'b0, 1'b0, '0);
    endtask

    task automatic enter_data(input string tag, input logic [NR-1:0] sel,
                              input logic [NR-1:0] exp_rg);
        drive(1'b0, 1'b1, sel, 1'b1, '0);
        step({tag, "_s1"}, S_START, 1'b0, 1'b0, exp_rg);
        step({tag, "_s2"}, S_START, 1'b0, 1'b0, exp_rg);
        step({tag, "_d0"}, S_DATA,  1'b0, 1'b0, exp_rg);
    endtask

    initial begin
        #1;
        rst = 1'b1;
        step("rst0", S_IDLE, 1'b0, 1'b0, '0);
        step("rst1", S_IDLE, 1'b0, 1'b0, '0);
        rst = 1'b0;
        idle_gap("gap0");

        // Region 1 read
        enter_data("t1", 5'b00010, 5'b00010);
        for (int i = 0; i < 5; i++) step("t1_wait", S_DATA, 1'b0, 1'b0, 5'b00010);
        region_ack = 5'b00010;
        step("t1_ack",  S_END, 1'b1, 1'b0, 5'b00010);
        step("t1_hold", S_END, 1'b1, 1'b0, 5'b00010);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step("t1_rel",  S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap1");

        // Foreign ack ignored; in the timeout build the real ack lands on the timeout edge
        enter_data("t2", 5'b00100, 5'b00100);
        region_ack = 5'b00001;
`ifdef Z3_SLAVE_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step("t2_foreign", S_DATA, 1'b0, 1'b0, 5'b00100);
`else
        for (int i = 0; i < 20; i++) step("t2_foreign", S_DATA, 1'b0, 1'b0, 5'b00100);
`endif
        region_ack = 5'b00101;
        step("t2_ack", S_END, 1'b1, 1'b0, 5'b00100);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step("t2_rel", S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap2");

        // No ack at all
        enter_data("t3", 5'b01000, 5'b01000);
`ifdef Z3_SLAVE_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step("t3_wait", S_DATA, 1'b0, 1'b0, 5'b01000);
        step("t3_berr", S_END, 1'b0, 1'b1, 5'b01000);
        step("t3_hold", S_END, 1'b0, 1'b1, 5'b01000);
`else
        for (int i = 0; i < 20; i++) step("t3_wait", S_DATA, 1'b0, 1'b0, 5'b01000);
`endif
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step("t3_rel", S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap3");

        // Abort in START, then abort in DATA
        drive(1'b0, 1'b1, 5'b00001, 1'b0, '0);
        step("t4_s", S_START, 1'b0, 1'b0, 5'b00001);
        step("t4_s", S_START, 1'b0, 1'b0, 5'b00001);
        fcs_n = 1'b1;
        step("t4_abort_start", S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap4");
        enter_data("t4b", 5'b00001, 5'b00001);
        step("t4b_d", S_DATA, 1'b0, 1'b0, 5'b00001);
        fcs_n = 1'b1;
        step("t4_abort_data", S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap5");

        // Multi-hot, empty select, no match
        drive(1'b0, 1'b1, 5'b10100, 1'b0, '0);
        step("t5_multi", S_START, 1'b0, 1'b0, 5'b00100);
        fcs_n = 1'b1;
        step("t5_multi_rel", S_IDLE, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b1, 5'b00000, 1'b0, '0);
        step("t5_empty", S_IDLE, 1'b0, 1'b0, '0);
        step("t5_empty", S_IDLE, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 5'b10000, 1'b0, '0);
        step("t5_nomatch", S_IDLE, 1'b0, 1'b0, '0);
        idle_gap("gap6");

        // Reset while in END with DTACK high and FCS still low
        enter_data("t6", 5'b10000, 5'b10000);
        region_ack = 5'b10000;
        step("t6_ack", S_END, 1'b1, 1'b0, 5'b10000);
        rst = 1'b1;
        step("t6_rst", S_IDLE, 1'b0, 1'b0, '0);
        rst = 1'b0;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        step("t6_after", S_IDLE, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
